arp_lookup: RTL and testbench



---
 rtl/arp_lookup_if.sv | 32 +++
 rtl/arp_lookup.sv | 152 +++++++++++++++
 tb/tb_arp_lookup.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_lookup_if.sv
// Bundles the search request/result and table register access signals of arp_lookup.
interface arp_lookup_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  arp_lookup_req;
  logic [31:0]           lookup_ip;
  logic                  arp_lookup_done;
  logic                  arp_hit;
  logic [47:0]           next_hop_mac;
  logic                  table_rd_req;
  logic [ADDR_WIDTH-1:0] table_rd_addr;
  logic [79:0]           table_rd_data;
  logic                  table_rd_ack;
  logic                  table_wr_req;
  logic [ADDR_WIDTH-1:0] table_wr_addr;
  logic [79:0]           table_wr_data;
  logic                  table_wr_ack;

  modport master (
    output arp_lookup_req, lookup_ip, table_rd_req, table_rd_addr,
           table_wr_req, table_wr_addr, table_wr_data,
    input  arp_lookup_done, arp_hit, next_hop_mac, table_rd_data,
           table_rd_ack, table_wr_ack
  );

  modport slave (
    input  arp_lookup_req, lookup_ip, table_rd_req, table_rd_addr,
           table_wr_req, table_wr_addr, table_wr_data,
    output arp_lookup_done, arp_hit, next_hop_mac, table_rd_data,
           table_rd_ack, table_wr_ack
  );
endinterface

// File: rtl/arp_lookup.sv
// Linear-search IP->MAC table: hit on entry k done at k+3, full miss at NUM_ENTRIES+2; req ignored while busy.
// Register port shares a dual-port RAM without stalls; ARP_LAST_HIT_CACHE_EN adds a last-hit bypass (done at cycle 1).
module arp_lookup #(
  parameter int NUM_ENTRIES = 32,
  parameter int ADDR_WIDTH  = 5
) (
  input logic         clk,
  input logic         reset,
  arp_lookup_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ENTRIES - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_COMPARE, ST_DONE} state_t;
  typedef enum logic [1:0] {ST_REG_IDLE, ST_REG_READ, ST_REG_WRITE} reg_state_t;

  logic [79:0]           mem [NUM_ENTRIES];
  logic [79:0]           rdata_a;
  state_t                state;
  reg_state_t            reg_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] cmp_idx;
  logic [31:0]           ip_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [79:0]           wr_data_q;

`ifdef ARP_LAST_HIT_CACHE_EN
  logic                  cache_vld;
  logic [31:0]           cache_ip;
  logic [47:0]           cache_mac;
`endif

  // Non-blocking read and write on the same edge gives read-first behaviour to both ports.
  always_ff @(posedge clk) begin
    if (reg_state == ST_REG_WRITE)
      mem[wr_addr_q] <= wr_data_q;
    rdata_a <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      addr                <= '0;
      cmp_idx             <= '0;
      ip_q                <= '0;
      bus.arp_lookup_done <= 1'b0;
      bus.arp_hit         <= 1'b0;
      bus.next_hop_mac    <= '0;
`ifdef ARP_LAST_HIT_CACHE_EN
      cache_vld           <= 1'b0;
      cache_ip            <= '0;
      cache_mac           <= '0;
`endif
    end else begin
      bus.arp_lookup_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.arp_lookup_req) begin
            ip_q    <= bus.lookup_ip;
            addr    <= '0;
            cmp_idx <= '0;
            if (bus.lookup_ip == '0) begin
              state               <= ST_DONE;
              bus.arp_lookup_done <= 1'b1;
              bus.arp_hit         <= 1'b0;
              bus.next_hop_mac    <= '0;
            end
`ifdef ARP_LAST_HIT_CACHE_EN
            else if (cache_vld && !bus.table_wr_ack && cache_ip == bus.lookup_ip) begin
              state               <= ST_DONE;
              bus.arp_lookup_done <= 1'b1;
              bus.arp_hit         <= 1'b1;
              bus.next_hop_mac    <= cache_mac;
            end
`endif
            else begin
              state <= ST_PRIME;
            end
          end
        end
        ST_PRIME: begin
          addr  <= addr + ONE;
          state <= ST_COMPARE;
        end
        ST_COMPARE: begin
          addr    <= addr + ONE;
          cmp_idx <= cmp_idx + ONE;
          if (rdata_a[31:0] == ip_q && rdata_a[31:0] != '0) begin
            state               <= ST_DONE;
            bus.arp_lookup_done <= 1'b1;
            bus.arp_hit         <= 1'b1;
            bus.next_hop_mac    <= rdata_a[79:32];
`ifdef ARP_LAST_HIT_CACHE_EN
            cache_vld           <= 1'b1;
            cache_ip            <= ip_q;
            cache_mac           <= rdata_a[79:32];
`endif
          end else if (cmp_idx == LAST_IDX) begin
            state               <= ST_DONE;
            bus.arp_lookup_done <= 1'b1;
            bus.arp_hit         <= 1'b0;
            bus.next_hop_mac    <= '0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
`ifdef ARP_LAST_HIT_CACHE_EN
      // A table write may change any entry, so it overrides a same-cycle cache load.
      if (bus.table_wr_ack)
        cache_vld <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_state         <= ST_REG_IDLE;
      bus.table_rd_ack  <= 1'b0;
      bus.table_wr_ack  <= 1'b0;
      bus.table_rd_data <= '0;
      wr_addr_q         <= '0;
      wr_data_q         <= '0;
    end else begin
      case (reg_state)
        ST_REG_IDLE: begin
          if (bus.table_wr_req) begin
            wr_addr_q        <= bus.table_wr_addr;
            wr_data_q        <= bus.table_wr_data;
            bus.table_wr_ack <= 1'b1;
            reg_state        <= ST_REG_WRITE;
          end else if (bus.table_rd_req) begin
            bus.table_rd_data <= mem[bus.table_rd_addr];
            bus.table_rd_ack  <= 1'b1;
            reg_state         <= ST_REG_READ;
          end
        end
        ST_REG_READ: begin
          bus.table_rd_ack <= 1'b0;
          reg_state        <= ST_REG_IDLE;
        end
        ST_REG_WRITE: begin
          bus.table_wr_ack <= 1'b0;
          reg_state        <= ST_REG_IDLE;
        end
        default: reg_state <= ST_REG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_lookup.sv
// Directed and randomized checks of arp_lookup against a table-scan reference model.
module tb_arp_lookup;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arp_lookup_if #(.ADDR_WIDTH(5)) bus ();

  arp_lookup #(.NUM_ENTRIES(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_ip  [32];
  logic [47:0] m_mac [32];
  bit          c_vld;
  logic [31:0] c_ip;
  logic [47:0] c_mac;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rnd_mac();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  // Reference: first matching nonzero IP in index order, or the last-hit cache when enabled.
  task automatic model_lookup(input logic [31:0] ip, output bit hit,
                              output logic [47:0] mac, output int lat);
    hit = 1'b0;
    mac = '0;
    lat = 34;
    if (ip == 32'd0) begin
      lat = 1;
      return;
    end
`ifdef ARP_LAST_HIT_CACHE_EN
    if (c_vld && c_ip == ip) begin
      hit = 1'b1;
      mac = c_mac;
      lat = 1;
      return;
    end
`endif
    for (int k = 0; k < 32; k++) begin
      if (m_ip[k] == ip) begin
        hit = 1'b1;
        mac = m_mac[k];
        lat = k + 3;
        break;
      end
    end
    if (hit) begin
      c_vld = 1'b1;
      c_ip  = ip;
      c_mac = mac;
    end
  endtask

  task automatic do_write(input int a, input logic [31:0] ip, input logic [47:0] mac);
    @(negedge clk);
    bus.table_wr_req  = 1'b1;
    bus.table_wr_addr = a[4:0];
    bus.table_wr_data = {mac, ip};
    @(posedge clk);
    @(negedge clk);
    check("wr_ack", 80'(bus.table_wr_ack), 80'(1));
    bus.table_wr_req = 1'b0;
    m_ip[a]  = ip;
    m_mac[a] = mac;
    c_vld    = 1'b0;
    @(negedge clk);
    check("wr_ack_width", 80'(bus.table_wr_ack), 80'(0));
  endtask

  task automatic do_read(input int a);
    @(negedge clk);
    bus.table_rd_req  = 1'b1;
    bus.table_rd_addr = a[4:0];
    @(posedge clk);
    @(negedge clk);
    check("rd_ack", 80'(bus.table_rd_ack), 80'(1));
    check("rd_data", bus.table_rd_data, {m_mac[a], m_ip[a]});
    bus.table_rd_req = 1'b0;
    @(negedge clk);
    check("rd_ack_width", 80'(bus.table_rd_ack), 80'(0));
  endtask

  task automatic do_lookup(input logic [31:0] ip);
    bit          e_hit;
    logic [47:0] e_mac;
    int          e_lat;
    int          c;
    model_lookup(ip, e_hit, e_mac, e_lat);
    @(negedge clk);
    bus.arp_lookup_req = 1'b1;
    bus.lookup_ip      = ip;
    @(posedge clk);
    @(negedge clk);
    bus.arp_lookup_req = 1'b0;
    c = 1;
    while (bus.arp_lookup_done !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("lookup_latency", 80'(c), 80'(e_lat));
    check("lookup_hit", 80'(bus.arp_hit), 80'(e_hit));
    check("lookup_mac", 80'(bus.next_hop_mac), 80'(e_mac));
    @(negedge clk);
    check("done_width", 80'(bus.arp_lookup_done), 80'(0));
  endtask

  initial begin
    bit seen;
    reset              = 1'b1;
    bus.arp_lookup_req = 1'b0;
    bus.lookup_ip      = '0;
    bus.table_rd_req   = 1'b0;
    bus.table_rd_addr  = '0;
    bus.table_wr_req   = 1'b0;
    bus.table_wr_addr  = '0;
    bus.table_wr_data  = '0;
    c_vld              = 1'b0;
    c_ip               = '0;
    c_mac              = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_done", 80'(bus.arp_lookup_done), 80'(0));
    check("reset_hit", 80'(bus.arp_hit), 80'(0));
    check("reset_mac", 80'(bus.next_hop_mac), 80'(0));
    check("reset_rd_ack", 80'(bus.table_rd_ack), 80'(0));
    check("reset_wr_ack", 80'(bus.table_wr_ack), 80'(0));

    for (int k = 0; k < 32; k++) do_write(k, 32'd0, rnd_mac());

    do_write(5, 32'h0a000005, 48'h004e46324305);
    do_lookup(32'h0a000005);
    check("plan_hit5_mac", 80'(bus.next_hop_mac), 80'(48'h004e46324305));
    do_lookup(32'h0a000063);

    do_write(3, 32'h0a000007, 48'h0000aaaa0003);
    do_write(7, 32'h0a000007, 48'h0000bbbb0007);
    do_lookup(32'h0a000007);
    check("plan_lowest_index_mac", 80'(bus.next_hop_mac), 80'(48'h0000aaaa0003));
    do_lookup(32'h00000000);

    do_lookup(32'h0a000005);
    do_lookup(32'h0a000005);
    do_write(20, 32'd0, rnd_mac());
    do_lookup(32'h0a000005);

    // Write and read requested together: write wins, read is served afterwards.
    @(negedge clk);
    bus.table_wr_req  = 1'b1;
    bus.table_wr_addr = 5'd4;
    bus.table_wr_data = {48'h0000cccc0004, 32'h0a000004};
    bus.table_rd_req  = 1'b1;
    bus.table_rd_addr = 5'd2;
    @(posedge clk);
    @(negedge clk);
    check("sim_wr_ack", 80'(bus.table_wr_ack), 80'(1));
    check("sim_rd_ack_early", 80'(bus.table_rd_ack), 80'(0));
    bus.table_wr_req = 1'b0;
    m_ip[4]  = 32'h0a000004;
    m_mac[4] = 48'h0000cccc0004;
    c_vld    = 1'b0;
    @(negedge clk);
    check("sim_rd_ack_gap", 80'(bus.table_rd_ack), 80'(0));
    @(negedge clk);
    check("sim_rd_ack", 80'(bus.table_rd_ack), 80'(1));
    check("sim_rd_data", bus.table_rd_data, {m_mac[2], m_ip[2]});
    bus.table_rd_req = 1'b0;
    @(negedge clk);
    do_lookup(32'h0a000004);

    for (int i = 0; i < 40; i++) begin
      int op;
      int a;
      logic [31:0] ip;
      op = $urandom_range(0, 2);
      a  = $urandom_range(0, 31);
      if (op == 0) begin
        ip = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'h0a000000 + $urandom_range(1, 12);
        do_write(a, ip, rnd_mac());
      end else if (op == 1) begin
        do_read(a);
      end else begin
        ip = 32'h0a000000 + $urandom_range(0, 14);
        do_lookup(ip);
        do_lookup(ip);
      end
    end

    // Reset arrives partway through a full-miss search.
    do_write(0, 32'h0a0000c8, 48'h00112233c8c8);
    @(negedge clk);
    bus.arp_lookup_req = 1'b1;
    bus.lookup_ip      = 32'h0a000063;
    @(posedge clk);
    @(negedge clk);
    bus.arp_lookup_req = 1'b0;
    seen = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (bus.arp_lookup_done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    c_vld = 1'b0;
    check("midrst_done", 80'(bus.arp_lookup_done), 80'(0));
    check("midrst_hit", 80'(bus.arp_hit), 80'(0));
    check("midrst_mac", 80'(bus.next_hop_mac), 80'(0));
    check("midrst_acks", 80'({bus.table_rd_ack, bus.table_wr_ack}), 80'(0));
    for (int c = 0; c < 40; c++) begin
      if (bus.arp_lookup_done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("midrst_no_done", 80'(seen), 80'(0));
    do_lookup(32'h0a0000c8);
    do_read(0);
    do_read(5);
    do_read(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
